// File: rtl/tanimoto_hit_collector.sv
// Tags every comparator result with {query, reference} indices and buffers the hits
// in a first-word-fall-through FIFO. The FIFO drains through a valid/ready stream.
module tanimoto_hit_collector #(
  parameter int REF_CNT    = 1024,
  parameter int REF_ID_W   = $clog2(REF_CNT),
  parameter int QRY_ID_W   = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH),
  parameter int DROP_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_Hit,
  input  logic                         i_Valid,
  input  logic                         i_SoftClr,
  output logic [QRY_ID_W+REF_ID_W-1:0] o_HitData,
  output logic                         o_HitValid,
  input  logic                         i_HitReady,
  output logic                         o_QueryDone,
  output logic                         o_Overflow,
  output logic [DROP_W-1:0]            o_DropCnt,
  output logic [FIFO_AW:0]             o_Level
);

  localparam int DW = QRY_ID_W + REF_ID_W;
  localparam logic [REF_ID_W-1:0] REF_LAST = REF_ID_W'(REF_CNT - 1);
  localparam logic [FIFO_AW:0]    LVL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [DROP_W-1:0]   DROP_MAX = '1;

  logic [REF_ID_W-1:0] ref_idx_q, ref_idx_d;
  logic [QRY_ID_W-1:0] qry_idx_q, qry_idx_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                done_q, done_d;
  logic [DW-1:0]       mem [FIFO_DEPTH];

  logic push_req, push_acc, pop, drop, full, hit_valid;

  // Stream handshake: a word transfers on every cycle where o_HitValid and
  // i_HitReady are both high; while valid is high without ready, o_HitData holds
  // and valid stays high. The producer side has no ready, so a hit meeting a full
  // FIFO without a simultaneous pop is dropped and counted instead of stalling.
  assign hit_valid = (level_q != '0);
  assign full      = (level_q == LVL_FULL);
  assign push_req  = i_Valid & i_Hit;
  assign pop       = hit_valid & i_HitReady;
  assign push_acc  = push_req & (~full | pop);
  assign drop      = push_req & ~push_acc;

  always_comb begin
    ref_idx_d  = ref_idx_q;
    qry_idx_d  = qry_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    done_d     = 1'b0;
    if (i_SoftClr) begin
      ref_idx_d  = '0;
      qry_idx_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (i_Valid) begin
        if (ref_idx_q == REF_LAST) begin
          ref_idx_d = '0;
          qry_idx_d = qry_idx_q + 1'b1;
          done_d    = 1'b1;
        end else begin
          ref_idx_d = ref_idx_q + 1'b1;
        end
      end
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_acc, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_idx_q  <= '0;
      qry_idx_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      ref_idx_q  <= ref_idx_d;
      qry_idx_q  <= qry_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      done_q     <= done_d;
    end
  end

  // Storage needs no reset: the pointers and level alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push_acc && !i_SoftClr) mem[wr_ptr_q] <= {qry_idx_q, ref_idx_q};
  end

  assign o_HitValid  = hit_valid;
  assign o_HitData   = hit_valid ? mem[rd_ptr_q] : '0;
  assign o_QueryDone = done_q;
  assign o_Overflow  = overflow_q;
  assign o_DropCnt   = drop_cnt_q;
  assign o_Level     = level_q;

endmodule

// File: tb/tb_tanimoto_hit_collector.sv
// Directed bench for tanimoto_hit_collector: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_tanimoto_hit_collector;

  localparam int REF_CNT    = 4;
  localparam int RW         = 2;
  localparam int QW         = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = 2;
  localparam int DROP_W     = 3;
  localparam int DW         = QW + RW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_Hit = 1'b0, i_Valid = 1'b0, i_SoftClr = 1'b0, i_HitReady = 1'b0;
  logic [DW-1:0]     o_HitData;
  logic              o_HitValid, o_QueryDone, o_Overflow;
  logic [DROP_W-1:0] o_DropCnt;
  logic [AW:0]       o_Level;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  tanimoto_hit_collector #(
    .REF_CNT(REF_CNT), .QRY_ID_W(QW), .FIFO_DEPTH(FIFO_DEPTH), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst), .i_Hit(i_Hit), .i_Valid(i_Valid), .i_SoftClr(i_SoftClr),
    .o_HitData(o_HitData), .o_HitValid(o_HitValid), .i_HitReady(i_HitReady),
    .o_QueryDone(o_QueryDone), .o_Overflow(o_Overflow), .o_DropCnt(o_DropCnt),
    .o_Level(o_Level)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, indices as plain integers.
  logic [DW-1:0] exp_q[$];
  int m_qry = 0, m_ref = 0, m_drop = 0;
  bit m_ovf = 1'b0, m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_qry = 0; m_ref = 0; m_drop = 0; m_ovf = 1'b0; m_done = 1'b0;
    end else if (i_SoftClr) begin
      exp_q.delete();
      m_qry = 0; m_ref = 0; m_drop = 0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin
      bit popped;
      popped = (exp_q.size() > 0) && i_HitReady;
      if (popped) void'(exp_q.pop_front());
      m_done = 1'b0;
      if (i_Valid) begin
        if (i_Hit) begin
          if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(DW'(m_qry * REF_CNT + m_ref));
          else begin
            m_ovf = 1'b1;
            if (m_drop < (2 ** DROP_W) - 1) m_drop++;
          end
        end
        m_ref++;
        if (m_ref == REF_CNT) begin
          m_ref = 0;
          m_qry = (m_qry + 1) % (2 ** QW);
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare: outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 32'(o_Level), 32'(exp_q.size()));
      chk("hit_valid", 32'(o_HitValid), 32'(exp_q.size() != 0));
      chk("hit_data", 32'(o_HitData), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      chk("query_done", 32'(o_QueryDone), 32'(m_done));
      chk("overflow", 32'(o_Overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(o_DropCnt), 32'(m_drop));
    end
  end

  // Driver: inputs change just after the falling edge, sampled at the next rising edge.
  task automatic step(input bit v, input bit h, input bit r, input bit sc);
    @(negedge clk);
    #1;
    i_Valid = v; i_Hit = h; i_HitReady = r; i_SoftClr = sc;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(o_HitValid), 32'd0);
    chk("rst_data", 32'(o_HitData), 32'd0);
    chk("rst_level", 32'(o_Level), 32'd0);
    chk("rst_ovf", 32'(o_Overflow), 32'd0);
    chk("rst_drop", 32'(o_DropCnt), 32'd0);
    chk("rst_done", 32'(o_QueryDone), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Tagging and query-done: hits at positions 1 and 6 of 8 valids.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 1) || (i == 6), 1'b1, 1'b0);
      if (i == 2) begin
        chk("t1_first_valid", 32'(o_HitValid), 32'd1);
        chk("t1_first_tag", 32'(o_HitData), 32'h1);
      end
      if (i == 4) chk("t1_done_q0", 32'(o_QueryDone), 32'd1);
      if (i == 5) chk("t1_done_low", 32'(o_QueryDone), 32'd0);
      if (i == 7) chk("t1_second_tag", 32'(o_HitData), 32'h6);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_done_q1", 32'(o_QueryDone), 32'd1);

    // Query index wrap: 18 hits, query tag wraps 3 -> 0.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 13) chk("t6_tag_q3", 32'(o_HitData), 32'hC);
      if (i == 17) begin
        chk("t6_wrap_valid", 32'(o_HitValid), 32'd1);
        chk("t6_wrap_tag", 32'(o_HitData), 32'h0);
      end
    end

    // Overflow: 6 hits into a depth-4 FIFO with no consumer.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_level", 32'(o_Level), 32'd4);
    chk("t2_drop", 32'(o_DropCnt), 32'd2);
    chk("t2_ovf", 32'(o_Overflow), 32'd1);
    chk("t2_head", 32'(o_HitData), 32'h0);
    chk("t2_head_valid", 32'(o_HitValid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_head_stable", 32'(o_HitData), 32'h0);

    // Full FIFO with simultaneous pop accepts the push.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_level", 32'(o_Level), 32'd4);
    chk("t3_drop", 32'(o_DropCnt), 32'd2);
    chk("t3_head", 32'(o_HitData), 32'h1);

    // Drop counter saturation.
    repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_drop", 32'(o_DropCnt), 32'd7);

    // Soft clear with three entries buffered and a colliding hit.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_pre_level", 32'(o_Level), 32'd3);
    chk("t4_pre_ovf", 32'(o_Overflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_valid", 32'(o_HitValid), 32'd0);
    chk("t4_level", 32'(o_Level), 32'd0);
    chk("t4_ovf", 32'(o_Overflow), 32'd0);
    chk("t4_drop", 32'(o_DropCnt), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_first_tag", 32'(o_HitData), 32'h0);
    chk("t4_level2", 32'(o_Level), 32'd2);

    // Asynchronous reset mid-cycle with two buffered entries and a hit arriving.
    @(negedge clk);
    #1;
    i_Valid = 1'b1; i_Hit = 1'b1; i_HitReady = 1'b0; i_SoftClr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid", 32'(o_HitValid), 32'd0);
    chk("t5_data", 32'(o_HitData), 32'd0);
    chk("t5_level", 32'(o_Level), 32'd0);
    chk("t5_ovf_drop_done", 32'({o_Overflow, o_DropCnt, o_QueryDone}), 32'd0);
    i_Valid = 1'b0; i_Hit = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_first_tag", 32'(o_HitData), 32'h0);
    chk("t5_valid_after", 32'(o_HitValid), 32'd1);

    // Mixed traffic with intermittent ready to exercise full-with-pop paths.
    for (int i = 0; i < 40; i++) step(1'b1, (i % 3) != 0, (i % 4) == 1, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_level", 32'(o_Level), 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
